writeback_unit: RTL and testbench

- Single owner of the register-file write port. Merges single-cycle ALU results with long-latency results (loads, mul/div) into one registered write per cycle.
- Long-latency results are buffered in a small FIFO whenever the ALU holds the port.
- Keeps a per-register pending scoreboard. Decode uses it to stall RAW and WAW hazards on in-flight long-latency destinations.
- Sits directly upstream of the register file; write_*_o connect straight to its write_data_i / write_addr_i / write_en_i.

---
 rtl/writeback_unit_if.sv | 33 +++
 rtl/writeback_unit.sv | 64 ++++++
 tb/tb_writeback_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: decode hazard query, ALU/LSU result inputs and register-file write port
interface writeback_unit_if #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
);
    localparam int AW = $clog2(REG_CNT);
    logic              issue_valid_i;
    logic [AW-1:0]     issue_rd_i;
    logic [AW-1:0]     rs1_i;
    logic [AW-1:0]     rs2_i;
    logic [AW-1:0]     rd_i;
    logic              hazard_o;
    logic              alu_valid_i;
    logic [AW-1:0]     alu_rd_i;
    logic [DATA_W-1:0] alu_data_i;
    logic              lsu_valid_i;
    logic [AW-1:0]     lsu_rd_i;
    logic [DATA_W-1:0] lsu_data_i;
    logic              lsu_ready_o;
    logic [DATA_W-1:0] write_data_o;
    logic [AW-1:0]     write_addr_o;
    logic              write_en_o;
    modport master (
        output issue_valid_i, issue_rd_i, rs1_i, rs2_i, rd_i,
        output alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  hazard_o, lsu_ready_o, write_data_o, write_addr_o, write_en_o
    );
    modport slave (
        input  issue_valid_i, issue_rd_i, rs1_i, rs2_i, rd_i,
        input  alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i,
        output hazard_o, lsu_ready_o, write_data_o, write_addr_o, write_en_o
    );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU and long-latency results onto one registered register-file write port
module writeback_unit #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32,
    parameter int REG_CNT    = 32
) (
    input logic             clk,
    input logic             rst,
    writeback_unit_if.slave bus
);
    localparam int AW = $clog2(REG_CNT);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [AW-1:0]      fifo_rd [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [PW:0]        count;
    logic [REG_CNT-1:0] pending, set_mask, clr_mask;
    logic               full, empty, accept, pop, bypass, push, sel_valid;
    logic [AW-1:0]      sel_rd;
    logic [DATA_W-1:0]  sel_data;
    assign full            = count == (PW+1)'(FIFO_DEPTH);
    assign empty           = count == '0;
    assign bus.lsu_ready_o = !full;
    assign bus.hazard_o    = pending[bus.rs1_i] | pending[bus.rs2_i] | pending[bus.rd_i];
    always_comb begin
        accept    = bus.lsu_valid_i & !full;
        pop       = !bus.alu_valid_i & !empty;
        bypass    = !bus.alu_valid_i & empty & accept;
        push      = accept & !bypass;
        sel_valid = bus.alu_valid_i | pop | bypass;
        sel_rd    = bus.alu_valid_i ? bus.alu_rd_i : pop ? fifo_rd[rd_ptr] : bus.lsu_rd_i;
        sel_data  = bus.alu_valid_i ? bus.alu_data_i : pop ? fifo_data[rd_ptr] : bus.lsu_data_i;
        clr_mask  = (pop | bypass) ? REG_CNT'(1) << sel_rd : '0;
        set_mask  = (bus.issue_valid_i && bus.issue_rd_i != '0) ? REG_CNT'(1) << bus.issue_rd_i : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.write_en_o   <= 1'b0;
            bus.write_addr_o <= '0;
            bus.write_data_o <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            pending          <= '0;
        end else begin
            bus.write_en_o <= sel_valid && sel_rd != '0;
            if (sel_valid) begin
                bus.write_addr_o <= sel_rd;
                bus.write_data_o <= sel_data;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count + (PW+1)'(push) - (PW+1)'(pop);
            // set after clear so a reissue in the retiring cycle stays pending
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.lsu_data_i;
            fifo_rd[wr_ptr]   <= bus.lsu_rd_i;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and random stimulus, expected writes queued from a behavioural model
module tb_writeback_unit;
    localparam int DEPTH = 2;
    typedef struct { logic [4:0] rd; logic [31:0] d; } res_t;
    typedef struct { bit en; bit ad; logic [4:0] a; logic [31:0] d; } exp_t;
    logic clk = 0, rst = 0;
    int n_cmp = 0, n_bad = 0;
    res_t lq[$];
    exp_t eq[$];
    bit pend[32];
    writeback_unit_if #(.DATA_W(32), .REG_CNT(32)) bus();
    writeback_unit #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .REG_CNT(32)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (eq.size() != 0) begin
            e = eq.pop_front();
            chk("write_en", 32'(bus.write_en_o), 32'(e.en));
            if (e.en || e.ad) begin
                chk("write_addr", 32'(bus.write_addr_o), 32'(e.a));
                chk("write_data", bus.write_data_o, e.d);
            end
        end
    end

    task automatic cycle(input bit r, input bit iv, input logic [4:0] ird, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d, input bit av, input logic [4:0] ard,
                         input logic [31:0] adat, input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
        exp_t e;
        res_t h;
        bit acc;
        rst = r;
        bus.issue_valid_i = iv; bus.issue_rd_i = ird;
        bus.rs1_i = s1; bus.rs2_i = s2; bus.rd_i = d;
        bus.alu_valid_i = av; bus.alu_rd_i = ard; bus.alu_data_i = adat;
        bus.lsu_valid_i = lv; bus.lsu_rd_i = lrd; bus.lsu_data_i = ldat;
        #1;
        chk("hazard", 32'(bus.hazard_o), 32'(pend[s1] | pend[s2] | pend[d]));
        chk("lsu_ready", 32'(bus.lsu_ready_o), 32'(lq.size() < DEPTH));
        e = '{en: 0, ad: 0, a: 0, d: 0};
        if (r) begin
            e.ad = 1;
            lq.delete();
            foreach (pend[i]) pend[i] = 0;
        end else begin
            acc = lv && lq.size() < DEPTH;
            if (av) e = '{en: ard != 0, ad: 0, a: ard, d: adat};
            else if (lq.size() != 0) begin
                h = lq.pop_front();
                e = '{en: h.rd != 0, ad: 0, a: h.rd, d: h.d};
                pend[h.rd] = 0;
            end else if (acc) begin
                e = '{en: lrd != 0, ad: 0, a: lrd, d: ldat};
                pend[lrd] = 0;
                acc = 0;
            end
            if (acc) lq.push_back('{rd: lrd, d: ldat});
            if (iv && ird != 0) pend[ird] = 1;
        end
        eq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] q);
        cycle(0, 0, 0, q, q, q, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int budget;
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // bypass of a single long result
        cycle(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        cycle(0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
        idle(5);
        // ALU holds the port while two long results queue up
        cycle(0, 1, 7, 0, 0, 0, 1, 3, 32'h11, 1, 7, 32'hA0);
        cycle(0, 1, 8, 0, 0, 0, 1, 3, 32'h11, 1, 8, 32'hA1);
        cycle(0, 0, 0, 7, 8, 0, 1, 3, 32'h11, 1, 9, 32'hBAD);
        cycle(0, 0, 0, 7, 8, 0, 1, 3, 32'h11, 0, 0, 0);
        idle(7); idle(8); idle(8);
        // hazard tracking on rd=9
        cycle(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 9, 32'h99);
        idle(9);
        // reissue of rd=4 while its result pops
        cycle(0, 0, 0, 0, 0, 0, 1, 2, 32'h22, 1, 4, 32'h44);
        cycle(0, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4); idle(4);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h45);
        idle(4);
        // x0 destinations
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 32'h1, 1, 0, 32'hFFFF);
        idle(0); idle(0);
        // fill, then reset discards everything
        cycle(0, 1, 12, 0, 0, 0, 1, 1, 32'h1, 1, 12, 32'hC0);
        cycle(0, 1, 13, 0, 0, 0, 1, 1, 32'h1, 1, 13, 32'hC1);
        cycle(1, 0, 0, 12, 13, 0, 0, 0, 0, 0, 0, 0);
        idle(12); idle(13); idle(13);
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ird;
            bit iv;
            ird = 5'($urandom);
            iv = ($urandom_range(3) == 0) && !pend[ird];
            cycle($urandom_range(63) == 0, iv, ird, 5'($urandom), 5'($urandom), 5'($urandom),
                  $urandom_range(1) == 1, 5'($urandom), $urandom, $urandom_range(1) == 1,
                  5'($urandom), $urandom);
        end
        idle(0); idle(0); idle(0);
        budget = 0;
        while (eq.size() != 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (eq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected writes left, required 0", eq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
